// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the convolutional encoder and the Viterbi decoder.
// Both sides take generators and state encoding from here so branch labels always agree.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;

  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  // Trellis state is {sr[0], sr[1]}: most recent bit in the MSB.
  typedef logic [1:0] trellis_state_t;
  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    ENC_IDLE  = 2'd0,
    ENC_DATA  = 2'd1,
    ENC_TAIL1 = 2'd2,
    ENC_TAIL2 = 2'd3
  } enc_fsm_e;

endpackage

// File: rtl/conv_branch_sym.sv
// One trellis branch: input bit and current state give the coded symbol and next state.
// Pure combinational so the decoder's branch-metric logic can reuse it unchanged.
module conv_branch_sym
  import viterbi_pkg::*;
#(
  parameter logic [2:0] G0 = G0_DEF,
  parameter logic [2:0] G1 = G1_DEF
) (
  input  logic           b,
  input  trellis_state_t state,
  output sym_t           sym,
  output trellis_state_t next_state
);

  logic [2:0] taps;

  // state already holds {sr[0], sr[1]}, which is the generator tap order after the input
  assign taps       = {b, state};
  assign sym        = {^(G0 & taps), ^(G1 & taps)};
  assign next_state = {b, state[1]};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with valid/ready streaming and optional
// two-bit zero tail that terminates each frame in trellis state 00.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter logic [2:0] G0      = G0_DEF,
  parameter logic [2:0] G1      = G1_DEF,
  parameter bit         TAIL_EN = 1'b1,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [1:0]       out_sym,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       enc_state,
  output logic [CNT_W-1:0] sym_count
);

  enc_fsm_e       state_q, state_d;
  trellis_state_t tstate_q, tstate_d;
  logic           out_valid_q, out_valid_d;
  sym_t           out_sym_q, out_sym_d;
  logic           out_last_q, out_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           clr_q, clr_d;

  logic           accepting;
  logic           tailing;
  logic           out_free;
  logic           in_hs;
  logic           tail_load;
  logic           out_hs;
  logic           br_b;
  sym_t           br_sym;
  trellis_state_t br_next;

  assign accepting = (state_q == ENC_IDLE) || (state_q == ENC_DATA);
  assign tailing   = (state_q == ENC_TAIL1) || (state_q == ENC_TAIL2);
  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = accepting && out_free;
  assign in_hs     = in_valid && in_ready;
  assign tail_load = tailing && out_free;
  assign out_hs    = out_valid_q && out_ready;

  // Tail bits are zeros fed through the same branch logic as data.
  assign br_b = accepting ? in_bit : 1'b0;

  conv_branch_sym #(
    .G0(G0),
    .G1(G1)
  ) u_branch (
    .b         (br_b),
    .state     (tstate_q),
    .sym       (br_sym),
    .next_state(br_next)
  );

  always_comb begin
    state_d     = state_q;
    tstate_d    = tstate_q;
    out_valid_d = out_hs ? 1'b0 : out_valid_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;

    if (in_hs) begin
      out_valid_d = 1'b1;
      out_sym_d   = br_sym;
      out_last_d  = in_last && !TAIL_EN;
      tstate_d    = br_next;
      if (in_last) begin
        state_d = TAIL_EN ? ENC_TAIL1 : ENC_IDLE;
      end else begin
        state_d = ENC_DATA;
      end
    end else if (tail_load) begin
      out_valid_d = 1'b1;
      out_sym_d   = br_sym;
      tstate_d    = br_next;
      if (state_q == ENC_TAIL1) begin
        out_last_d = 1'b0;
        state_d    = ENC_TAIL2;
      end else begin
        out_last_d = 1'b1;
        state_d    = ENC_IDLE;
      end
    end
  end

  // The final count of a frame stays visible for one cycle, then clears.
  always_comb begin
    cnt_d = clr_q ? '0 : cnt_q;
    clr_d = 1'b0;
    if (out_hs) begin
      cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, 1'b1};
      clr_d = out_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ENC_IDLE;
      tstate_q    <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tstate_q    <= tstate_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
    end
  end

  assign out_sym   = out_sym_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign enc_state = tstate_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: a per-cycle vector table covering tail, back-to-back,
// reset-mid-tail and no-tail frames, plus a hand-written backpressure sequence.
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready_1, out_valid_1, out_last_1;
  logic [1:0]  out_sym_1, enc_state_1;
  logic [15:0] sym_count_1;
  logic        in_ready_0, out_valid_0, out_last_0;
  logic [1:0]  out_sym_0, enc_state_0;
  logic [15:0] sym_count_0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_encoder #(.TAIL_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_1), .out_sym(out_sym_1), .out_valid(out_valid_1),
    .out_last(out_last_1), .out_ready(out_ready), .enc_state(enc_state_1),
    .sym_count(sym_count_1)
  );

  conv_encoder #(.TAIL_EN(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_0), .out_sym(out_sym_0), .out_valid(out_valid_0),
    .out_last(out_last_0), .out_ready(out_ready), .enc_state(enc_state_0),
    .sym_count(sym_count_0)
  );

  typedef struct {
    bit          use0;
    bit          chk;
    bit          rst_n;
    bit          v, b, l, r;
    bit          ov;
    logic [1:0]  sym;
    bit          last;
    bit          ir;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit use0, chk, rst, v, b, l, r, ov,
                              input logic [1:0] sym, input bit last, ir,
                              input logic [1:0] st, input int cnt);
    vec_t x;
    x.use0 = use0; x.chk = chk; x.rst_n = rst;
    x.v = v; x.b = b; x.l = l; x.r = r;
    x.ov = ov; x.sym = sym; x.last = last; x.ir = ir; x.st = st;
    x.cnt = 16'(cnt);
    return x;
  endfunction

  logic       g_ov, g_last, g_ir;
  logic [1:0] g_sym, g_st;
  logic [15:0] g_cnt;
  bit         ok;

  logic [3:0] fbits;
  logic [1:0] exp_s [6];
  logic [1:0] held_sym;
  logic       held_last;
  bit         stalled_prev;
  int         idx, got, k;

  initial begin
    // columns: use0 chk rst | v b l r | ov sym last ir st cnt
    vecs.push_back(mk(0,0,0, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(0,0,0, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    // frame 1,0,1,1 -> 11,10,00,01,01,11
    vecs.push_back(mk(0,1,1, 1,1,0,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(0,1,1, 1,0,0,1, 1,2'b11,0,1,2'b10,0));
    vecs.push_back(mk(0,1,1, 1,1,0,1, 1,2'b10,0,1,2'b01,1));
    vecs.push_back(mk(0,1,1, 1,1,1,1, 1,2'b00,0,1,2'b10,2));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b01,0,0,2'b11,3));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b01,0,0,2'b01,4));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b11,1,1,2'b00,5));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,6));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    // one-bit frame 1 -> 11,10,11; count 1,2,3,0
    vecs.push_back(mk(0,1,1, 1,1,1,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b11,0,0,2'b10,0));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b10,0,0,2'b01,1));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b11,1,1,2'b00,2));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,3));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    // back-to-back 1,1 then 0,1; next bit held during the tail
    vecs.push_back(mk(0,1,1, 1,1,0,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(0,1,1, 1,1,1,1, 1,2'b11,0,1,2'b10,0));
    vecs.push_back(mk(0,1,1, 1,0,0,1, 1,2'b01,0,0,2'b11,1));
    vecs.push_back(mk(0,1,1, 1,0,0,1, 1,2'b01,0,0,2'b01,2));
    vecs.push_back(mk(0,1,1, 1,0,0,1, 1,2'b11,1,1,2'b00,3));
    vecs.push_back(mk(0,1,1, 1,1,1,1, 1,2'b00,0,1,2'b00,4));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b11,0,0,2'b10,1));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b10,0,0,2'b01,2));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b11,1,1,2'b00,3));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,4));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    // reset pulse during TAIL1, then frame 1 again
    vecs.push_back(mk(0,1,1, 1,1,1,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(0,1,0, 0,0,0,1, 1,2'b11,0,0,2'b10,0));
    vecs.push_back(mk(0,1,1, 1,1,1,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b11,0,0,2'b10,0));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b10,0,0,2'b01,1));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 1,2'b11,1,1,2'b00,2));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,3));
    vecs.push_back(mk(0,1,1, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    // no-tail instance: frame 1,1 -> 11,01; state 11 carries into next frame (bit 0 -> 01)
    vecs.push_back(mk(1,0,0, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(1,0,0, 0,0,0,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(1,1,1, 1,1,0,1, 0,2'b00,0,1,2'b00,0));
    vecs.push_back(mk(1,1,1, 1,1,1,1, 1,2'b11,0,1,2'b10,0));
    vecs.push_back(mk(1,1,1, 1,0,0,1, 1,2'b01,1,1,2'b11,1));
    vecs.push_back(mk(1,1,1, 0,0,0,1, 1,2'b01,0,1,2'b01,2));
    vecs.push_back(mk(1,1,1, 0,0,0,1, 0,2'b00,0,1,2'b01,1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; in_valid = vecs[i].v; in_bit = vecs[i].b;
      in_last = vecs[i].l; out_ready = vecs[i].r;
      #1;
      if (vecs[i].chk) begin
        g_ov   = vecs[i].use0 ? out_valid_0 : out_valid_1;
        g_sym  = vecs[i].use0 ? out_sym_0   : out_sym_1;
        g_last = vecs[i].use0 ? out_last_0  : out_last_1;
        g_ir   = vecs[i].use0 ? in_ready_0  : in_ready_1;
        g_st   = vecs[i].use0 ? enc_state_0 : enc_state_1;
        g_cnt  = vecs[i].use0 ? sym_count_0 : sym_count_1;
        ok = (g_ov === vecs[i].ov) && (g_ir === vecs[i].ir) &&
             (g_st === vecs[i].st) && (g_cnt === vecs[i].cnt) &&
             (!vecs[i].ov || ((g_sym === vecs[i].sym) && (g_last === vecs[i].last)));
        n_vec++;
        if (!ok) begin
          n_err++;
          $display("FAIL vec %0d: got ov=%b sym=%b last=%b ir=%b st=%b cnt=%0d, want ov=%b sym=%b last=%b ir=%b st=%b cnt=%0d",
                   i, g_ov, g_sym, g_last, g_ir, g_st, g_cnt,
                   vecs[i].ov, vecs[i].sym, vecs[i].last, vecs[i].ir, vecs[i].st, vecs[i].cnt);
        end
      end
    end

    // backpressure: frame 1,0,1,1 with out_ready 1,0,0,1 repeating
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    fbits = 4'b1101;  // bit idx 0..3 = 1,0,1,1
    exp_s[0] = 2'b11; exp_s[1] = 2'b10; exp_s[2] = 2'b00;
    exp_s[3] = 2'b01; exp_s[4] = 2'b01; exp_s[5] = 2'b11;
    idx = 0; got = 0; k = 0; stalled_prev = 0;
    held_sym = 2'b00; held_last = 1'b0;
    while (got < 6 && k < 60) begin
      @(negedge clk);
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      in_valid  = (idx < 4);
      in_bit    = (idx < 4) ? fbits[idx[1:0]] : 1'b0;
      in_last   = (idx == 3);
      #1;
      if (stalled_prev) begin
        n_vec++;
        if (out_valid_1 !== 1'b1 || out_sym_1 !== held_sym || out_last_1 !== held_last) begin
          n_err++;
          $display("FAIL stall_hold k=%0d: got v=%b sym=%b last=%b, want v=1 sym=%b last=%b",
                   k, out_valid_1, out_sym_1, out_last_1, held_sym, held_last);
        end
      end
      if (out_valid_1 && !out_ready) begin
        n_vec++;
        if (in_ready_1 !== 1'b0) begin
          n_err++;
          $display("FAIL stall_in_ready k=%0d: got %b, want 0", k, in_ready_1);
        end
        held_sym = out_sym_1; held_last = out_last_1; stalled_prev = 1;
      end else begin
        stalled_prev = 0;
      end
      if (out_valid_1 && out_ready) begin
        n_vec++;
        if (out_sym_1 !== exp_s[got] || out_last_1 !== (got == 5)) begin
          n_err++;
          $display("FAIL stall_sym %0d: got sym=%b last=%b, want sym=%b last=%b",
                   got, out_sym_1, out_last_1, exp_s[got], (got == 5));
        end
        got++;
      end
      if (in_valid && in_ready_1) idx++;
      k++;
    end
    if (got < 6) begin
      n_vec++; n_err++;
      $display("FAIL stall_timeout: got %0d symbols, want 6", got);
    end

    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
